// File: rtl/led_pattern_scheduler_pkg.sv
// Shared definitions for the DE2 green-LED pattern scheduler.
//   - mode codes (MODE_SHL .. MODE_BLINK) and bounce direction
//   - LED_W, SPEED_MAX and the LEDG reset pattern
//   - next_pattern(): the one-step pattern advance used by the top level
package led_pattern_scheduler_pkg;

    localparam int               LED_W     = 9;
    localparam logic [2:0]       SPEED_MAX = 3'd7;
    localparam logic [LED_W-1:0] LEDG_RST  = 9'h001;

    typedef enum logic [1:0] {
        MODE_SHL    = 2'd0,
        MODE_SHR    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    typedef struct packed {
        logic [LED_W-1:0] ledg;
        dir_t             dir;
    } pattern_t;

    // Pattern after one step. BOUNCE turns around at the end bits so the
    // walking bit never leaves the 9-bit window.
    function automatic pattern_t next_pattern(mode_t mode, logic [LED_W-1:0] ledg, dir_t dir);
        pattern_t p;
        p.ledg = ledg;
        p.dir  = dir;
        case (mode)
            MODE_SHL: p.ledg = {ledg[LED_W-2:0], ledg[LED_W-1]};
            MODE_SHR: p.ledg = {ledg[0], ledg[LED_W-1:1]};
            MODE_BOUNCE: begin
                if (dir == DIR_LEFT) begin
                    if (ledg[LED_W-1]) begin
                        p.dir  = DIR_RIGHT;
                        p.ledg = ledg >> 1;
                    end else begin
                        p.ledg = ledg << 1;
                    end
                end else begin
                    if (ledg[0]) begin
                        p.dir  = DIR_LEFT;
                        p.ledg = ledg << 1;
                    end else begin
                        p.ledg = ledg >> 1;
                    end
                end
            end
            default: p.ledg = {{(LED_W-1){1'b0}}, ~ledg[0]};  // MODE_BLINK
        endcase
        return p;
    endfunction

endpackage

// File: rtl/led_pattern_scheduler_key_debounce.sv
// key_debounce: one pushbutton conditioner.
//   2-flop synchroniser followed by a stable-level counter. A new level is
//   accepted after it has differed from the accepted level for DEBOUNCE_CYC
//   consecutive cycles; any gap restarts the count. An accepted 1->0 edge
//   produces a one-cycle press pulse; releases produce nothing.
// Ports:
//   CLOCK_50  in  system clock
//   RESET     in  synchronous active-high reset (state returns to released)
//   key_n     in  raw active-low button, asynchronous
//   press     out one-cycle pulse on an accepted press
module key_debounce #(
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic key_n,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_1;
    logic             sync_2;
    logic             accepted;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            accepted   <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 != accepted) begin
                // This cycle is the DEBOUNCE_CYC-th consecutive mismatch.
                if (stable_cnt == CNT_LAST) begin
                    accepted   <= sync_2;
                    stable_cnt <= '0;
                    press      <= ~sync_2;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/led_pattern_scheduler.sv
// led_pattern_scheduler: pushbutton-controlled LED pattern sequencer.
//   Debounces KEY[3:0] into press events, keeps mode/speed/run registers,
//   runs a prescaler of period BASE_DIV << (7-SPEED) and advances the LEDG
//   pattern (SHL, SHR, BOUNCE, BLINK) once per prescaler wrap.
// Ports:
//   CLOCK_50  in   system clock
//   RESET     in   synchronous active-high reset
//   KEY[3:0]  in   raw active-low buttons: 0 run/pause, 1 next mode,
//                  2 speed up, 3 speed down
//   LEDG[8:0] out  registered pattern
//   MODE[1:0] out  current mode (also the observable control state)
//   SPEED[2:0]out  speed index, 0 slowest .. 7 fastest
//   RUNNING   out  1 while the pattern advances
//   TICK      out  high in the cycle LEDG shows a new step
import led_pattern_scheduler_pkg::*;

module led_pattern_scheduler #(
    parameter int BASE_DIV     = 2_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int SPEED_RST    = 3
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [3:0] KEY,
    output logic [8:0] LEDG,
    output logic [1:0] MODE,
    output logic [2:0] SPEED,
    output logic       RUNNING,
    output logic       TICK
);

    localparam logic [31:0] BASE_PERIOD = 32'(BASE_DIV);
    localparam logic [2:0]  SPEED_INIT  = 3'(SPEED_RST);

    logic [3:0] press;
    logic       ev_run;
    logic       ev_mode;
    logic       ev_up;
    logic       ev_dn;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_key_debounce (
            .CLOCK_50(CLOCK_50),
            .RESET   (RESET),
            .key_n   (KEY[i]),
            .press   (press[i])
        );
    end

    assign ev_run  = press[0];
    assign ev_mode = press[1];
    assign ev_up   = press[2];
    assign ev_dn   = press[3];

    // State registers and their next values.
    mode_t            mode_q,  mode_d;
    logic [2:0]       speed_q, speed_d;
    logic             run_q,   run_d;
    logic             tick_q,  tick_d;
    logic [31:0]      presc_q, presc_d;
    logic [LED_W-1:0] ledg_q,  ledg_d;
    dir_t             dir_q,   dir_d;

    logic [31:0] period_m1;
    logic        at_wrap;
    logic        step;
    pattern_t    nxt;

    assign period_m1 = (BASE_PERIOD << (SPEED_MAX - speed_q)) - 32'd1;
    assign at_wrap   = (presc_q == period_m1);
    assign nxt       = next_pattern(mode_q, ledg_q, dir_q);

    // Process 1: state register.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            mode_q  <= MODE_SHL;
            speed_q <= SPEED_INIT;
            run_q   <= 1'b1;
            tick_q  <= 1'b0;
            presc_q <= '0;
            ledg_q  <= LEDG_RST;
            dir_q   <= DIR_LEFT;
        end else begin
            mode_q  <= mode_d;
            speed_q <= speed_d;
            run_q   <= run_d;
            tick_q  <= tick_d;
            presc_q <= presc_d;
            ledg_q  <= ledg_d;
            dir_q   <= dir_d;
        end
    end

    // Process 2: next state. Step decisions use the current RUNNING and
    // SPEED; a mode change takes priority over a step on the same edge.
    // A speed change clears the prescaler but does not cancel a wrap that
    // lands on the same edge (the prescaler ends at 0 either way).
    always_comb begin
        mode_d  = mode_q;
        speed_d = speed_q;
        run_d   = run_q;
        presc_d = presc_q;
        ledg_d  = ledg_q;
        dir_d   = dir_q;
        step    = run_q && at_wrap && !ev_mode;
        tick_d  = step;

        if (ev_run) begin
            run_d = ~run_q;
        end

        if (ev_up && !ev_dn && speed_q != SPEED_MAX) begin
            speed_d = speed_q + 3'd1;
        end else if (ev_dn && !ev_up && speed_q != 3'd0) begin
            speed_d = speed_q - 3'd1;
        end

        if (ev_mode || ev_up || ev_dn) begin
            presc_d = '0;
        end else if (run_q) begin
            presc_d = at_wrap ? 32'd0 : presc_q + 32'd1;
        end

        if (ev_mode) begin
            mode_d = mode_t'(mode_q + 2'd1);
            ledg_d = LEDG_RST;
            dir_d  = DIR_LEFT;
        end else if (step) begin
            ledg_d = nxt.ledg;
            dir_d  = nxt.dir;
        end
    end

    // Process 3: outputs, all straight from registers.
    assign LEDG    = ledg_q;
    assign MODE    = mode_q;
    assign SPEED   = speed_q;
    assign RUNNING = run_q;
    assign TICK    = tick_q;

endmodule
